mcs_trace_capture: RTL and testbench

Consumer for the MicroBlaze MCS trace bus. It samples the per-instruction trace outputs (PC, instruction, register write-back, data writes) and starts on a software-free arm/trigger condition. Captured records go into an on-chip FIFO, which a downstream debug drain (for example a UART dumper) empties through a valid/ready handshake. It sits beside the MCS instance in the top level and is fed by the wires that are currently left unconnected for waveform debugging only.

---
 rtl/mcs_trace_pkg.sv | 62 ++++++
 rtl/mcs_trace_capture_fifo.sv | 65 ++++++
 rtl/mcs_trace_capture.sv | 148 ++++++++++++++
 tb/tb_mcs_trace_capture.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcs_trace_pkg.sv
// mcs_trace_pkg
//   Shared encodings and record layout for the MicroBlaze MCS trace capture
//   block: record kinds, FSM state codes, the S1 trace sample layout and the
//   packed capture record (kind, pc, addr, data = 98 bits).
package mcs_trace_pkg;

    // Record kinds
    localparam logic [1:0] KIND_INSTR = 2'd0;
    localparam logic [1:0] KIND_REG   = 2'd1;
    localparam logic [1:0] KIND_DATA  = 2'd2;

    // Capture FSM states
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ARMED     = 2'd1;
    localparam logic [1:0] ST_CAPTURING = 2'd2;
    localparam logic [1:0] ST_STOPPED   = 2'd3;

    // Width of one stored record
    localparam int REC_W = 98;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_rec_t;

    // One registered sample of the MCS trace bus
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        reg_write;
        logic [4:0]  reg_addr;
        logic [31:0] new_reg_val;
        logic        data_write;
        logic [31:0] data_addr;
        logic [31:0] data_write_val;
        logic        halted;
    } trace_s1_t;

    // Data write outranks register write, which outranks a plain instruction.
    function automatic trace_rec_t form_record(trace_s1_t s);
        trace_rec_t r;
        r.pc = s.pc;
        if (s.data_write) begin
            r.kind = KIND_DATA;
            r.addr = s.data_addr;
            r.data = s.data_write_val;
        end else if (s.reg_write) begin
            r.kind = KIND_REG;
            r.addr = {27'b0, s.reg_addr};
            r.data = s.new_reg_val;
        end else begin
            r.kind = KIND_INSTR;
            r.addr = '0;
            r.data = s.instruction;
        end
        return r;
    endfunction

endpackage

// File: rtl/mcs_trace_capture_fifo.sv
// trace_fifo
//   Synchronous FIFO with first-word-fall-through head.
//   Parameters: WIDTH (entry width), DEPTH (entries, power of two).
//   Ports:
//     clk, reset       clock, asynchronous active-high reset (empties FIFO)
//     push, push_data  write request; accepted when not full, or when full
//                      and a pop happens in the same cycle
//     pop              read request; ignored when empty
//     full, empty      status
//     head_data        current head entry, forced to zero while empty
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    assign do_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the slot the write lands in
    // (wr_ptr == rd_ptr); the head is read before the edge, so it is safe.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mcs_trace_capture.sv
// mcs_trace_capture
//   Captures MicroBlaze MCS trace activity into an on-chip FIFO once armed
//   and triggered, for a downstream debug drain over valid/ready.
//   Parameter: DEPTH  FIFO entries (power of two, 4..256).
//   Ports:
//     clk, reset                  clock, asynchronous active-high reset
//     arm, stop                   single-cycle control pulses (stop wins)
//     trig_en, trig_pc            PC-match trigger enable and value
//     tr_*                        MCS trace bus, registered once (S1)
//     out_valid/out_ready         FIFO head handshake
//     out_kind/out_pc/out_addr/out_data   head record fields
//     state                       0 IDLE, 1 ARMED, 2 CAPTURING, 3 STOPPED
//     dropped                     saturating count of records lost to full
module mcs_trace_capture
    import mcs_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic        stop,
    input  logic        trig_en,
    input  logic [31:0] trig_pc,
    input  logic        tr_valid_instruction,
    input  logic [31:0] tr_pc,
    input  logic [31:0] tr_instruction,
    input  logic        tr_reg_write,
    input  logic [4:0]  tr_reg_addr,
    input  logic [31:0] tr_new_reg_val,
    input  logic        tr_data_write,
    input  logic [31:0] tr_data_addr,
    input  logic [31:0] tr_data_write_val,
    input  logic        tr_halted,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_kind,
    output logic [31:0] out_pc,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic [1:0]  state,
    output logic [15:0] dropped
);

    trace_s1_t  s1_d;
    trace_s1_t  s1;
    trace_rec_t rec;
    trace_rec_t head_rec;
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [15:0] dropped_q;
    logic       trig_fire;
    logic       arm_go;
    logic       capture;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       drop;

    // ---------------- S1: register the whole trace bus ----------------
    always_comb begin
        s1_d                = '0;
        s1_d.valid          = tr_valid_instruction;
        s1_d.pc             = tr_pc;
        s1_d.instruction    = tr_instruction;
        s1_d.reg_write      = tr_reg_write;
        s1_d.reg_addr       = tr_reg_addr;
        s1_d.new_reg_val    = tr_new_reg_val;
        s1_d.data_write     = tr_data_write;
        s1_d.data_addr      = tr_data_addr;
        s1_d.data_write_val = tr_data_write_val;
        s1_d.halted         = tr_halted;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) s1 <= '0;
        else       s1 <= s1_d;
    end

    assign rec = form_record(s1);

    // ---------------- control FSM ----------------
    // Trigger is judged on the S1 sample; a stop in the same cycle cancels it.
    assign trig_fire = (state_q == ST_ARMED) & ~stop &
                       (~trig_en | (s1.valid & (s1.pc == trig_pc)));

    // Arm only takes effect from IDLE or STOPPED and loses to stop.
    assign arm_go = arm & ~stop & ((state_q == ST_IDLE) | (state_q == ST_STOPPED));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (arm_go) state_d = ST_ARMED;
            ST_ARMED: begin
                if (stop)           state_d = ST_STOPPED;
                else if (trig_fire) state_d = ST_CAPTURING;
            end
            ST_CAPTURING: if (stop | s1.halted) state_d = ST_STOPPED;
            ST_STOPPED:   if (arm_go) state_d = ST_ARMED;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // The triggering instruction and the stopping/halting one are both kept.
    assign capture = s1.valid & ((state_q == ST_CAPTURING) | trig_fire);

    // ---------------- FIFO and drain ----------------
    assign pop  = out_valid & out_ready;
    assign drop = capture & fifo_full & ~pop;

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (rec),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_rec)
    );

    // ---------------- dropped counter ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dropped_q <= '0;
        else if (arm_go)
            dropped_q <= '0;
        else if (drop && dropped_q != 16'hFFFF)
            dropped_q <= dropped_q + 16'd1;
    end

    assign out_valid = ~fifo_empty;
    assign out_kind  = head_rec.kind;
    assign out_pc    = head_rec.pc;
    assign out_addr  = head_rec.addr;
    assign out_data  = head_rec.data;
    assign state     = state_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_mcs_trace_capture.sv
module tb_mcs_trace_capture;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic        arm, stop, trig_en;
    logic [31:0] trig_pc;
    logic        tr_valid_instruction;
    logic [31:0] tr_pc, tr_instruction, tr_new_reg_val;
    logic        tr_reg_write;
    logic [4:0]  tr_reg_addr;
    logic        tr_data_write;
    logic [31:0] tr_data_addr, tr_data_write_val;
    logic        tr_halted;
    logic        out_valid, out_ready;
    logic [1:0]  out_kind;
    logic [31:0] out_pc, out_addr, out_data;
    logic [1:0]  state;
    logic [15:0] dropped;

    int n_pass;
    int n_chk;

    mcs_trace_capture #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop),
        .trig_en(trig_en), .trig_pc(trig_pc),
        .tr_valid_instruction(tr_valid_instruction), .tr_pc(tr_pc),
        .tr_instruction(tr_instruction), .tr_reg_write(tr_reg_write),
        .tr_reg_addr(tr_reg_addr), .tr_new_reg_val(tr_new_reg_val),
        .tr_data_write(tr_data_write), .tr_data_addr(tr_data_addr),
        .tr_data_write_val(tr_data_write_val), .tr_halted(tr_halted),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
        .state(state), .dropped(dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (queue based) ----------------
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    rec_t mq[$];
    int   m_state = 0;
    int   m_drop  = 0;
    bit   m_s1_v  = 0;
    bit   m_s1_h  = 0;
    logic [31:0] m_s1_pc = '0;
    rec_t m_s1_rec = '0;

    function automatic rec_t mk_rec();
        rec_t r;
        r.pc = tr_pc;
        if (tr_data_write) begin
            r.kind = 2'd2; r.addr = tr_data_addr; r.data = tr_data_write_val;
        end else if (tr_reg_write) begin
            r.kind = 2'd1; r.addr = {27'b0, tr_reg_addr}; r.data = tr_new_reg_val;
        end else begin
            r.kind = 2'd0; r.addr = 32'd0; r.data = tr_instruction;
        end
        return r;
    endfunction

    task automatic model_edge();
        bit do_pop, trig, cap;
        int n;
        n      = mq.size();
        do_pop = (n > 0) && out_ready;
        trig   = (m_state == 1) && !stop && (!trig_en || (m_s1_v && m_s1_pc == trig_pc));
        cap    = m_s1_v && (m_state == 2 || trig);
        if (do_pop) void'(mq.pop_front());
        if (cap) begin
            if (n < DEPTH || do_pop) mq.push_back(m_s1_rec);
            else if (m_drop < 65535) m_drop++;
        end
        case (m_state)
            0: if (arm && !stop) begin m_state = 1; m_drop = 0; end
            1: if (stop) m_state = 3; else if (trig) m_state = 2;
            2: if (stop || m_s1_h) m_state = 3;
            default: if (!stop && arm) begin m_state = 1; m_drop = 0; end
        endcase
        m_s1_v   = tr_valid_instruction;
        m_s1_h   = tr_halted;
        m_s1_pc  = tr_pc;
        m_s1_rec = mk_rec();
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_state = 0; m_drop = 0; m_s1_v = 0; m_s1_h = 0;
            m_s1_pc = '0; m_s1_rec = '0;
        end else begin
            model_edge();
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_cmp();
        chk("m_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("m_state", 32'(state), 32'(m_state));
        chk("m_dropped", 32'(dropped), 32'(m_drop));
        if (mq.size() > 0) begin
            chk("m_kind", 32'(out_kind), 32'(mq[0].kind));
            chk("m_pc", out_pc, mq[0].pc);
            chk("m_addr", out_addr, mq[0].addr);
            chk("m_data", out_data, mq[0].data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_cmp();
    endtask

    task automatic clear_tr();
        tr_valid_instruction = 0; tr_pc = '0; tr_instruction = '0;
        tr_reg_write = 0; tr_reg_addr = '0; tr_new_reg_val = '0;
        tr_data_write = 0; tr_data_addr = '0; tr_data_write_val = '0;
        tr_halted = 0; arm = 0; stop = 0;
    endtask

    task automatic put_instr(logic [31:0] pc, logic [31:0] ins);
        clear_tr();
        tr_valid_instruction = 1; tr_pc = pc; tr_instruction = ins;
    endtask

    task automatic pulse_arm();
        arm = 1; tick(); arm = 0;
    endtask

    // Check the head, then pop it with a single ready cycle.
    task automatic drain_expect(string nm, logic [1:0] k, logic [31:0] pc,
                                logic [31:0] a, logic [31:0] d);
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_kind"}, 32'(out_kind), 32'(k));
        chk({nm, "_pc"}, out_pc, pc);
        chk({nm, "_addr"}, out_addr, a);
        chk({nm, "_data"}, out_data, d);
        out_ready = 1; tick(); out_ready = 0;
    endtask

    // ---------------- record-formation vector table ----------------
    typedef struct {
        logic        v, rw, dw;
        logic [4:0]  ra;
        logic [31:0] rv, da, dv, ins, pc;
        logic        present;
        logic [1:0]  ek;
        logic [31:0] ea, ed;
    } vec_t;

    vec_t vt[6];
    bit   hold;

    initial begin
        n_pass = 0; n_chk = 0;
        vt[0] = '{1, 1, 1, 5'd3,  32'hDEADBEEF, 32'h2000, 32'h55, 32'h11, 32'h200, 1, 2'd2, 32'h2000, 32'h55};
        vt[1] = '{1, 1, 0, 5'd3,  32'hDEADBEEF, 32'h0, 32'h0, 32'h22, 32'h204, 1, 2'd1, 32'h3, 32'hDEADBEEF};
        vt[2] = '{1, 0, 0, 5'd7,  32'h1, 32'h0, 32'h0, 32'h12345678, 32'h208, 1, 2'd0, 32'h0, 32'h12345678};
        vt[3] = '{0, 1, 1, 5'd9,  32'h2, 32'h3000, 32'h66, 32'h33, 32'h20C, 0, 2'd0, 32'h0, 32'h0};
        vt[4] = '{1, 0, 1, 5'd0,  32'h0, 32'hFFFFFFFC, 32'hCAFEF00D, 32'h44, 32'h210, 1, 2'd2, 32'hFFFFFFFC, 32'hCAFEF00D};
        vt[5] = '{1, 1, 0, 5'd31, 32'h0, 32'h0, 32'h0, 32'h55, 32'h214, 1, 2'd1, 32'h1F, 32'h0};

        // ---- reset ----
        reset = 1; clear_tr(); out_ready = 0; trig_en = 0; trig_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_dropped", 32'(dropped), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_data", out_data, 32'd0);
        #2 reset = 0;
        tick();

        // ---- immediate capture, latency ----
        trig_en = 0; out_ready = 1;
        pulse_arm();
        chk("imm_armed", 32'(state), 32'd1);
        put_instr(32'h0, 32'hA0); tick();
        chk("imm_lat_n1", 32'(out_valid), 32'd0);
        put_instr(32'h4, 32'hA4); tick();
        chk("imm_lat_n2", 32'(out_valid), 32'd1);
        chk("imm_pc0", out_pc, 32'h0);
        chk("imm_data0", out_data, 32'hA0);
        chk("imm_kind0", 32'(out_kind), 32'd0);
        put_instr(32'h8, 32'hA8); tick();
        chk("imm_pc4", out_pc, 32'h4);
        clear_tr(); tick();
        chk("imm_pc8", out_pc, 32'h8);
        tick();
        chk("imm_empty", 32'(out_valid), 32'd0);

        // ---- stop, later instructions ignored ----
        out_ready = 0;
        stop = 1; tick(); stop = 0;
        chk("stop_state", 32'(state), 32'd3);
        put_instr(32'h40, 32'h1); tick(); clear_tr(); tick(); tick();
        chk("stop_ignored", 32'(out_valid), 32'd0);

        // ---- PC trigger ----
        trig_en = 1; trig_pc = 32'h100;
        pulse_arm();
        chk("trig_armed", 32'(state), 32'd1);
        put_instr(32'hF8, 32'h1); tick();
        put_instr(32'hFC, 32'h2); tick();
        put_instr(32'h100, 32'h3); tick();
        chk("trig_n1", 32'(state), 32'd1);
        put_instr(32'h104, 32'h4); tick();
        chk("trig_n2", 32'(state), 32'd2);
        clear_tr(); tick(); tick();
        drain_expect("trig_r0", 2'd0, 32'h100, 32'h0, 32'h3);
        drain_expect("trig_r1", 2'd0, 32'h104, 32'h0, 32'h4);
        chk("trig_empty", 32'(out_valid), 32'd0);

        // ---- record formation table ----
        foreach (vt[i]) begin
            clear_tr();
            tr_valid_instruction = vt[i].v; tr_reg_write = vt[i].rw;
            tr_data_write = vt[i].dw; tr_reg_addr = vt[i].ra;
            tr_new_reg_val = vt[i].rv; tr_data_addr = vt[i].da;
            tr_data_write_val = vt[i].dv; tr_instruction = vt[i].ins;
            tr_pc = vt[i].pc;
            tick();
        end
        clear_tr(); tick(); tick();
        foreach (vt[i])
            if (vt[i].present) drain_expect($sformatf("vec%0d", i), vt[i].ek, vt[i].pc, vt[i].ea, vt[i].ed);
        chk("vec_empty", 32'(out_valid), 32'd0);

        // ---- overflow ----
        for (int i = 0; i < 20; i++) begin
            put_instr(32'h1000 + 32'(i) * 4, 32'(i)); tick();
        end
        clear_tr(); tick(); tick();
        chk("ovf_dropped", 32'(dropped), 32'd4);
        chk("ovf_head", out_pc, 32'h1000);
        put_instr(32'h2000, 32'h99); tick();
        clear_tr(); out_ready = 1; tick(); out_ready = 0;
        chk("ovf_pushpop_dropped", 32'(dropped), 32'd4);
        chk("ovf_pushpop_head", out_pc, 32'h1004);
        for (int i = 1; i < 16; i++)
            drain_expect($sformatf("ovf%0d", i), 2'd0, 32'h1000 + 32'(i) * 4, 32'h0, 32'(i));
        drain_expect("ovf_last", 2'd0, 32'h2000, 32'h0, 32'h99);
        chk("ovf_empty", 32'(out_valid), 32'd0);

        // ---- halt ----
        put_instr(32'h300, 32'h7); tr_halted = 1; tick();
        clear_tr(); tick();
        chk("halt_state", 32'(state), 32'd3);
        chk("halt_captured", out_pc, 32'h300);
        put_instr(32'h304, 32'h8); tick(); clear_tr(); tick(); tick();
        drain_expect("halt_r", 2'd0, 32'h300, 32'h0, 32'h7);
        chk("halt_after_empty", 32'(out_valid), 32'd0);

        // ---- stop and arm together ----
        arm = 1; stop = 1; tick(); clear_tr();
        chk("sa_stopped", 32'(state), 32'd3);
        trig_en = 0;
        pulse_arm(); tick();
        chk("sa_capturing", 32'(state), 32'd2);
        arm = 1; stop = 1; tick(); clear_tr();
        chk("sa_cap_stopped", 32'(state), 32'd3);

        // ---- asynchronous reset mid-capture ----
        pulse_arm();
        for (int i = 0; i < 5; i++) begin
            put_instr(32'h500 + 32'(i) * 4, 32'(i)); tick();
        end
        clear_tr(); tick(); tick();
        chk("rm_capturing", 32'(state), 32'd2);
        chk("rm_queued", 32'(out_valid), 32'd1);
        #3 reset = 1;
        #1;
        chk("rm_valid", 32'(out_valid), 32'd0);
        chk("rm_state", 32'(state), 32'd0);
        chk("rm_dropped", 32'(dropped), 32'd0);
        chk("rm_pc", out_pc, 32'd0);
        #2 reset = 0;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rm_no_stale", 32'(out_valid), 32'd0);
        end

        // ---- randomized run against the model ----
        trig_pc = 32'h40;
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 120 == 0) hold = ($urandom_range(0, 2) == 0);
            arm  = ($urandom_range(0, 24) == 0);
            stop = ($urandom_range(0, 39) == 0);
            if (arm) trig_en = 1'($urandom_range(0, 1));
            tr_valid_instruction = ($urandom_range(0, 9) < 7);
            tr_pc = ($urandom_range(0, 3) == 0) ? trig_pc : (32'($urandom_range(0, 255)) << 2);
            tr_instruction = $urandom();
            tr_reg_write = ($urandom_range(0, 9) < 3);
            tr_reg_addr = 5'($urandom());
            tr_new_reg_val = $urandom();
            tr_data_write = ($urandom_range(0, 9) < 2);
            tr_data_addr = $urandom();
            tr_data_write_val = $urandom();
            tr_halted = ($urandom_range(0, 99) == 0);
            out_ready = hold ? 1'b0 : ($urandom_range(0, 9) < 6);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
